// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a 64-line, 4-word direct-mapped cache array.
// Optional hit/miss statistics outputs are enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl #(
    parameter int MEM_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_inv,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_ready,
    output logic [31:0] cache_addr,
    output logic        cache_store,
    output logic        cache_edit,
    output logic        cache_invalid,
    output logic [31:0] cache_din,
    input  logic        cache_hit,
    input  logic [31:0] cache_dout,
    input  logic        cache_valid,
    input  logic        cache_dirty,
    input  logic [21:0] cache_tag,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    input  logic [31:0] mem_din,
    input  logic        mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BACK = 2'd1,
        FILL = 2'd2,
        INV  = 2'd3
    } state_t;

    localparam logic [1:0] LAST_WORD = 2'(MEM_WORDS - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] line_base_s;
    logic [31:0] victim_base_s;

    assign line_base_s   = {cpu_addr[31:4], cnt_q, 2'b00};
    assign victim_base_s = {cache_tag, cpu_addr[9:4], cnt_q, 2'b00};

    // State and word-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; every output is held at zero during reset.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cpu_dout      = 32'd0;
        cpu_ready     = 1'b0;
        cache_addr    = 32'd0;
        cache_store   = 1'b0;
        cache_edit    = 1'b0;
        cache_invalid = 1'b0;
        cache_din     = 32'd0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'd0;
        mem_dout      = 32'd0;
        if (!rst) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cache_addr = cpu_addr;
                    if (!cpu_req) begin
                        state_d = IDLE;
                    end else if (cpu_inv) begin
                        // A dirty resident line must reach memory before it is dropped.
                        if (cache_hit && cache_dirty) begin
                            state_d = BACK;
                            cnt_d   = 2'd0;
                        end else begin
                            cache_invalid = 1'b1;
                            cpu_ready     = 1'b1;
                        end
                    end else if (cache_hit) begin
                        cpu_ready = 1'b1;
                        if (cpu_we) begin
                            cache_edit = 1'b1;
                            cache_din  = cpu_din;
                        end else begin
                            cpu_dout = cache_dout;
                        end
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = (cache_valid && cache_dirty) ? BACK : FILL;
                    end
                end
                BACK: begin
                    cache_addr = line_base_s;
                    mem_addr   = victim_base_s;
                    mem_cs     = 1'b1;
                    mem_we     = 1'b1;
                    mem_dout   = cache_dout;
                    if (mem_ack) begin
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == LAST_WORD) begin
                            state_d = cpu_inv ? INV : FILL;
                        end else begin
                            state_d = BACK;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                FILL: begin
                    cache_addr = line_base_s;
                    mem_addr   = line_base_s;
                    mem_cs     = 1'b1;
                    if (mem_ack) begin
                        cache_store = 1'b1;
                        cache_din   = mem_din;
                        cnt_d       = cnt_q + 2'd1;
                        if (cnt_q == LAST_WORD) begin
                            state_d = IDLE;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                INV: begin
                    cache_addr    = cpu_addr;
                    cache_invalid = 1'b1;
                    cpu_ready     = 1'b1;
                    state_d       = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic        hit_evt_s;
    logic        miss_evt_s;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    assign hit_evt_s  = rst && (state_q == IDLE) && cpu_req && !cpu_inv && cache_hit;
    assign miss_evt_s = rst && (state_q == IDLE) && cpu_req && !cpu_inv && !cache_hit;

    // Free-running hit/miss statistics, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (hit_evt_s) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt_s) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a behavioural cache array and
// a memory model whose acknowledge latency is programmable.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_inv;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_ready;
    logic [31:0] cache_addr, cache_din, cache_dout;
    logic        cache_store, cache_edit, cache_invalid;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [21:0] cache_tag;
    logic        mem_cs, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_dout, mem_din;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    cache_ctrl #(.MEM_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_inv(cpu_inv),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
        .cache_addr(cache_addr), .cache_store(cache_store), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_din(cache_din), .cache_hit(cache_hit),
        .cache_dout(cache_dout), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
        .cache_tag(cache_tag),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Behavioural cache array: combinational lookup, clocked write port.
    logic [21:0] tag_m   [64];
    logic        valid_m [64];
    logic        dirty_m [64];
    logic [31:0] data_m  [64][4];
    logic        arr_clr;
    logic [5:0]  idx_s;
    logic [1:0]  wrd_s;

    always_comb begin
        idx_s       = cache_addr[9:4];
        wrd_s       = cache_addr[3:2];
        cache_tag   = tag_m[idx_s];
        cache_valid = valid_m[idx_s];
        cache_dirty = dirty_m[idx_s];
        cache_hit   = valid_m[idx_s] && (tag_m[idx_s] == cache_addr[31:10]);
        cache_dout  = data_m[idx_s][wrd_s];
    end

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int i = 0; i < 64; i++) begin
                valid_m[i] <= 1'b0;
                dirty_m[i] <= 1'b0;
            end
        end else if (cache_store) begin
            data_m[idx_s][wrd_s] <= cache_din;
            tag_m[idx_s]         <= cache_addr[31:10];
            valid_m[idx_s]       <= 1'b1;
            dirty_m[idx_s]       <= 1'b0;
        end else if (cache_edit) begin
            data_m[idx_s][wrd_s] <= cache_din;
            dirty_m[idx_s]       <= 1'b1;
        end else if (cache_invalid) begin
            valid_m[idx_s] <= 1'b0;
        end
    end

    // Memory model: read data derived from address, writes and strobes logged.
    int          ack_delay = 0;
    int          wait_n = 0;
    int          store_n = 0, wr_n = 0, edit_n = 0, inv_n = 0;
    logic [31:0] store_log [256];
    logic [31:0] wr_addr_log [256];
    logic [31:0] wr_data_log [256];

    always_comb begin
        mem_ack = mem_cs && (wait_n == ack_delay);
        mem_din = (mem_addr[10] ? 32'h4444_4440 : 32'h1111_1110) + {30'd0, mem_addr[3:2]};
    end

    always @(posedge clk) begin
        if (!mem_cs || mem_ack) wait_n <= 0;
        else wait_n <= wait_n + 1;
        if (mem_cs && mem_we && mem_ack) begin
            wr_addr_log[wr_n[7:0]] <= mem_addr;
            wr_data_log[wr_n[7:0]] <= mem_dout;
            wr_n <= wr_n + 1;
        end
        if (cache_store) begin
            store_log[store_n[7:0]] <= cache_addr;
            store_n <= store_n + 1;
        end
        if (cache_edit) edit_n <= edit_n + 1;
        if (cache_invalid) inv_n <= inv_n + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until cpu_ready (bounded), report dout and latency.
    task automatic do_req(input logic we, input logic inv, input logic [31:0] addr,
                          input logic [31:0] din, output logic [31:0] dout, output int cyc);
        cpu_req = 1'b1; cpu_we = we; cpu_inv = inv; cpu_addr = addr; cpu_din = din;
        cyc = -1; dout = 32'd0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                cyc  = c;
                dout = cpu_dout;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_inv = 1'b0;
    endtask

    logic [31:0] d;
    int          cyc, s0, w0, e0, i0;

    initial begin
        rst = 1'b0; arr_clr = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_inv = 1'b0;
        cpu_addr = 32'h0000_0123; cpu_din = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_cache_addr", cache_addr, 32'd0);
        check("rst_edit", {31'd0, cache_edit}, 32'd0);
        check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; arr_clr = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0;
`ifdef CACHE_CTRL_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        // Cold read miss, zero-wait memory.
        s0 = store_n; w0 = wr_n;
        do_req(1'b0, 1'b0, 32'h0000_0004, 32'd0, d, cyc);
        check("cold_cyc", 32'(cyc), 32'd5);
        check("cold_dout", d, 32'h1111_1111);
        check("cold_nstore", 32'(store_n - s0), 32'd4);
        for (int i = 0; i < 4; i++) check("cold_store_addr", store_log[s0 + i], 32'(4 * i));
        check("cold_nwr", 32'(wr_n - w0), 32'd0);

        // Write hit then read back.
        e0 = edit_n;
        do_req(1'b1, 1'b0, 32'h0000_0008, 32'h2222_2222, d, cyc);
        check("wr_hit_cyc", 32'(cyc), 32'd0);
        check("wr_hit_nedit", 32'(edit_n - e0), 32'd1);
        do_req(1'b0, 1'b0, 32'h0000_0008, 32'd0, d, cyc);
        check("rd_hit_cyc", 32'(cyc), 32'd0);
        check("rd_hit_dout", d, 32'h2222_2222);

        // Dirty conflict miss: write back four words, refill four words.
        s0 = store_n; w0 = wr_n;
        do_req(1'b0, 1'b0, 32'h0000_0408, 32'd0, d, cyc);
        check("dirty_cyc", 32'(cyc), 32'd9);
        check("dirty_dout", d, 32'h4444_4442);
        check("dirty_nwr", 32'(wr_n - w0), 32'd4);
        for (int i = 0; i < 4; i++) check("dirty_wb_addr", wr_addr_log[w0 + i], 32'(4 * i));
        check("dirty_wb_d0", wr_data_log[w0 + 0], 32'h1111_1110);
        check("dirty_wb_d1", wr_data_log[w0 + 1], 32'h1111_1111);
        check("dirty_wb_d2", wr_data_log[w0 + 2], 32'h2222_2222);
        check("dirty_wb_d3", wr_data_log[w0 + 3], 32'h1111_1113);
        for (int i = 0; i < 4; i++) check("dirty_fill_addr", store_log[s0 + i], 32'h400 + 32'(4 * i));

        // Invalidate a clean resident line, then it misses again.
        do_req(1'b0, 1'b0, 32'h0000_00A8, 32'd0, d, cyc);
        check("a8_fill_cyc", 32'(cyc), 32'd5);
        check("a8_fill_dout", d, 32'h1111_1112);
        i0 = inv_n; w0 = wr_n;
        do_req(1'b0, 1'b1, 32'h0000_00A8, 32'd0, d, cyc);
        check("inv_clean_cyc", 32'(cyc), 32'd0);
        check("inv_clean_ninv", 32'(inv_n - i0), 32'd1);
        check("inv_clean_nwr", 32'(wr_n - w0), 32'd0);
        do_req(1'b0, 1'b0, 32'h0000_00A8, 32'd0, d, cyc);
        check("a8_remiss_cyc", 32'(cyc), 32'd5);

        // Invalidate a dirty hit: write back first, then drop the line.
        do_req(1'b1, 1'b0, 32'h0000_0404, 32'h5555_5555, d, cyc);
        check("wr404_cyc", 32'(cyc), 32'd0);
        w0 = wr_n; i0 = inv_n;
        do_req(1'b0, 1'b1, 32'h0000_0404, 32'd0, d, cyc);
        check("inv_dirty_cyc", 32'(cyc), 32'd5);
        check("inv_dirty_nwr", 32'(wr_n - w0), 32'd4);
        check("inv_dirty_addr1", wr_addr_log[w0 + 1], 32'h0000_0404);
        check("inv_dirty_data1", wr_data_log[w0 + 1], 32'h5555_5555);
        check("inv_dirty_data0", wr_data_log[w0 + 0], 32'h4444_4440);
        check("inv_dirty_ninv", 32'(inv_n - i0), 32'd1);
        do_req(1'b0, 1'b0, 32'h0000_0400, 32'd0, d, cyc);
        check("after_inv_cyc", 32'(cyc), 32'd5);
        check("after_inv_dout", d, 32'h4444_4440);

        // Slow memory: cs/addr held between acks; reset during word 2.
        ack_delay = 3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_inv = 1'b0; cpu_addr = 32'h0000_0800;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("slow_cs", {31'd0, mem_cs}, (c >= 1) ? 32'd1 : 32'd0);
            if (c >= 1) check("slow_addr", mem_addr, 32'h800 + 32'(4 * ((c - 1) / 4)));
        end
        @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit", hit_cnt, 32'd8);
        check("stats_miss", miss_cnt, 32'd6);
`endif
        rst = 1'b0;
        #1;
        check("midrst_cs", {31'd0, mem_cs}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_cache_addr", cache_addr, 32'd0);
        check("midrst_store", {31'd0, cache_store}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("postrst_cs", {31'd0, mem_cs}, 32'd0);
        check("postrst_cache_addr", cache_addr, 32'h0000_0800);
`ifdef CACHE_CTRL_STATS_EN
        check("postrst_hit", hit_cnt, 32'd0);
        check("postrst_miss", miss_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h0000_0800, 32'd0, d, cyc);
        check("postrst_hit_cyc", 32'(cyc), 32'd0);
        check("postrst_dout", d, 32'h1111_1110);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
